// File: rtl/adc_capture_trigger_pkg.sv
// adc_capture_trigger_pkg: shared widths, FSM state codes and the lane crossing detector.
package adc_capture_trigger_pkg;
    localparam int SAMPLE_W = 8;
    localparam int WORD_W = 32;
    localparam int LANES = 4;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_ARMED = 2'd1;
    localparam logic [1:0] ST_RECORD = 2'd2;
    localparam logic [1:0] ST_DONE = 2'd3;

    // Lanes run oldest to newest; the oldest lane pairs with the previous word's newest sample.
    function automatic logic crossing(
        input logic [SAMPLE_W-1:0] prev,
        input logic prev_valid,
        input logic [WORD_W-1:0] word,
        input logic [SAMPLE_W-1:0] th,
        input logic falling
    );
        logic hit;
        logic valid;
        logic [SAMPLE_W-1:0] p;
        logic [SAMPLE_W-1:0] c;
        hit = 1'b0;
        valid = prev_valid;
        p = prev;
        for (int i = 0; i < LANES; i++) begin
            c = word[WORD_W-1-i*SAMPLE_W -: SAMPLE_W];
            if (valid)
                hit = hit | (falling ? (p >= th && c < th) : (p < th && c >= th));
            p = c;
            valid = 1'b1;
        end
        return hit;
    endfunction
endpackage

// File: rtl/capture_delay_line.sv
// capture_delay_line: fixed-depth word shift register with a saturating fill counter since clear.
module capture_delay_line #(
    parameter int DEPTH = 8,
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clear,
    input  logic [W-1:0] din,
    output logic [W-1:0] dout,
    output logic         full
);
    localparam int FW = $clog2(DEPTH + 1);

    logic [W-1:0] sr [DEPTH];
    logic [FW-1:0] fill;

    assign dout = sr[DEPTH-1];
    assign full = fill == FW'(DEPTH);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fill <= '0;
            for (int i = 0; i < DEPTH; i++) sr[i] <= '0;
        end else begin
            sr[0] <= din;
            for (int i = 1; i < DEPTH; i++) sr[i] <= sr[i-1];
            fill <= clear ? '0 : full ? fill : fill + 1'b1;
        end
    end
endmodule

// File: rtl/adc_capture_trigger.sv
// adc_capture_trigger: armed level-crossing trigger emitting a fixed-length FIFO write burst.
// Optional pre-trigger history via CAPTURE_PRETRIGGER_EN.
module adc_capture_trigger
    import adc_capture_trigger_pkg::*;
#(
    parameter int LEN_W = 16,
    parameter int PRE_DEPTH = 8
) (
    input  logic              Clock,
    input  logic              Reset,
    input  logic [31:0]       DataIn,
    input  logic              Arm,
    input  logic              ForceTrigger,
    input  logic [7:0]        Threshold,
    input  logic              FallingSlope,
    input  logic [LEN_W-1:0]  RecordLength,
    input  logic              FifoNotFull,
    output logic              WriteStrobe,
    output logic [31:0]       DataOut,
    output logic              Triggered,
    output logic              Busy,
    output logic              Done,
    output logic              Overflow
);
    if (PRE_DEPTH < 1) begin : g_bad_depth
        $error("PRE_DEPTH must be at least 1");
    end

    logic [1:0] state;
    logic [1:0] state_n;
    logic [LEN_W-1:0] len_q;
    logic [LEN_W-1:0] cnt;
    logic [SAMPLE_W-1:0] prev;
    logic prev_valid;
    logic arm_ok;
    logic fire;
    logic ready;
    logic [WORD_W-1:0] word_out;

`ifdef CAPTURE_PRETRIGGER_EN
    capture_delay_line #(.DEPTH(PRE_DEPTH), .W(WORD_W)) u_delay (
        .clk(Clock),
        .rst(Reset),
        .clear(arm_ok),
        .din(DataIn),
        .dout(word_out),
        .full(ready)
    );
`else
    assign word_out = DataIn;
    assign ready = 1'b1;
`endif

    assign arm_ok = Arm && (state == ST_IDLE || state == ST_DONE);
    assign fire = state == ST_ARMED && ready &&
                  (ForceTrigger || crossing(prev, prev_valid, DataIn, Threshold, FallingSlope));

    always_comb begin
        state_n = arm_ok ? ST_ARMED :
                  fire ? (len_q == '0 ? ST_DONE : ST_RECORD) :
                  (state == ST_RECORD && cnt == len_q) ? ST_DONE : state;
    end

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state <= ST_IDLE;
            len_q <= '0;
            cnt <= '0;
            prev <= '0;
            prev_valid <= 1'b0;
            WriteStrobe <= 1'b0;
            DataOut <= '0;
            Triggered <= 1'b0;
            Busy <= 1'b0;
            Done <= 1'b0;
            Overflow <= 1'b0;
        end else begin
            state <= state_n;
            len_q <= arm_ok ? RecordLength : len_q;
            cnt <= arm_ok ? '0 : state_n == ST_RECORD ? cnt + 1'b1 : cnt;
            prev <= state == ST_ARMED ? DataIn[SAMPLE_W-1:0] : prev;
            prev_valid <= arm_ok ? 1'b0 : state == ST_ARMED ? 1'b1 : prev_valid;
            WriteStrobe <= state_n == ST_RECORD;
            DataOut <= state_n == ST_RECORD ? word_out : DataOut;
            Triggered <= arm_ok ? 1'b0 : (fire && len_q != '0) ? 1'b1 : Triggered;
            Busy <= state_n == ST_ARMED || state_n == ST_RECORD;
            Done <= state_n == ST_DONE;
            // A dropped word still counts so the record keeps its time alignment.
            Overflow <= arm_ok ? 1'b0 : Overflow | (WriteStrobe & ~FifoNotFull);
        end
    end
endmodule

// File: tb/tb_adc_capture_trigger.sv
// tb_adc_capture_trigger: table-driven directed check of the capture trigger (default build).
module tb_adc_capture_trigger;
    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] din;
    logic        arm, frc, fall, fnf;
    logic [7:0]  th;
    logic [15:0] len;
    logic        ws, trig, busy, done, ovf;
    logic [31:0] dout;
    int          n_cmp = 0;
    int          n_bad = 0;

    typedef struct {
        logic arm, frc, fall, fnf;
        logic [7:0] th;
        logic [15:0] len;
        logic [31:0] din;
        logic [4:0] st;
        logic [31:0] dout;
    } vec_t;

    vec_t tbl[36];

    adc_capture_trigger dut (
        .Clock(clk), .Reset(rst), .DataIn(din), .Arm(arm), .ForceTrigger(frc),
        .Threshold(th), .FallingSlope(fall), .RecordLength(len), .FifoNotFull(fnf),
        .WriteStrobe(ws), .DataOut(dout), .Triggered(trig), .Busy(busy), .Done(done),
        .Overflow(ovf)
    );

    always #5 clk = ~clk;

    function automatic vec_t mk(logic a, logic f, logic fl, logic nf, logic [15:0] l,
                                logic [31:0] d, logic [4:0] s, logic [31:0] o);
        vec_t v;
        v.arm = a; v.frc = f; v.fall = fl; v.fnf = nf; v.th = 8'h80;
        v.len = l; v.din = d; v.st = s; v.dout = o;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step(input vec_t v, input string name);
        arm = v.arm; frc = v.frc; fall = v.fall; fnf = v.fnf;
        th = v.th; len = v.len; din = v.din;
        @(posedge clk);
        #1;
        check({name, " status{ws,trig,busy,done,ovf}"}, 32'({ws, trig, busy, done, ovf}), 32'(v.st));
        check({name, " dout"}, dout, v.dout);
    endtask

    initial begin
        // status bits: {ws, trig, busy, done, ovf}
        tbl[0]  = mk(1, 0, 0, 1, 5, 32'h10101010, 5'b00100, 32'h0);
        tbl[1]  = mk(0, 0, 0, 1, 5, 32'h10101010, 5'b00100, 32'h0);
        tbl[2]  = mk(0, 0, 0, 1, 5, 32'h10109090, 5'b11100, 32'h10109090);
        tbl[3]  = mk(0, 0, 0, 1, 5, 32'hAA000003, 5'b11100, 32'hAA000003);
        tbl[4]  = mk(0, 0, 0, 1, 5, 32'hAA000004, 5'b11100, 32'hAA000004);
        tbl[5]  = mk(0, 0, 0, 1, 5, 32'hAA000005, 5'b11100, 32'hAA000005);
        tbl[6]  = mk(0, 0, 0, 1, 5, 32'hAA000006, 5'b11100, 32'hAA000006);
        tbl[7]  = mk(0, 0, 0, 1, 5, 32'h00000000, 5'b01010, 32'hAA000006);
        tbl[8]  = mk(1, 0, 1, 1, 2, 32'h20000000, 5'b00100, 32'hAA000006);
        tbl[9]  = mk(0, 0, 1, 1, 2, 32'h20202020, 5'b00100, 32'hAA000006);
        tbl[10] = mk(0, 0, 1, 1, 2, 32'hA0A0A090, 5'b00100, 32'hAA000006);
        tbl[11] = mk(0, 0, 1, 1, 2, 32'h20A0A0A0, 5'b11100, 32'h20A0A0A0);
        tbl[12] = mk(0, 0, 1, 1, 2, 32'h11111111, 5'b11100, 32'h11111111);
        tbl[13] = mk(0, 0, 1, 1, 2, 32'h00000000, 5'b01010, 32'h11111111);
        tbl[14] = mk(1, 0, 0, 1, 3, 32'h00000000, 5'b00100, 32'h11111111);
        tbl[15] = mk(0, 1, 0, 1, 3, 32'h00000000, 5'b11100, 32'h0);
        tbl[16] = mk(0, 0, 0, 1, 3, 32'h00000000, 5'b11100, 32'h0);
        tbl[17] = mk(0, 0, 0, 1, 3, 32'h00000000, 5'b11100, 32'h0);
        tbl[18] = mk(0, 0, 0, 1, 3, 32'h00000000, 5'b01010, 32'h0);
        tbl[19] = mk(1, 0, 0, 1, 0, 32'h00000000, 5'b00100, 32'h0);
        tbl[20] = mk(0, 1, 0, 1, 0, 32'h00000000, 5'b00010, 32'h0);
        tbl[21] = mk(1, 0, 0, 1, 10, 32'h00000000, 5'b00100, 32'h0);
        tbl[22] = mk(0, 1, 0, 1, 10, 32'h00000001, 5'b11100, 32'h1);
        tbl[23] = mk(0, 0, 0, 0, 10, 32'h00000002, 5'b11101, 32'h2);
        tbl[24] = mk(0, 0, 0, 0, 10, 32'h00000003, 5'b11101, 32'h3);
        for (int i = 25; i <= 31; i++)
            tbl[i] = mk(0, 0, 0, 1, 10, 32'(i - 21), 5'b11101, 32'(i - 21));
        tbl[32] = mk(0, 0, 0, 1, 10, 32'h00000000, 5'b01011, 32'hA);
        tbl[33] = mk(1, 0, 0, 1, 1, 32'h00000000, 5'b00100, 32'hA);
        tbl[34] = mk(1, 1, 0, 1, 4, 32'h00000055, 5'b11100, 32'h55);
        tbl[35] = mk(0, 0, 0, 1, 4, 32'h00000066, 5'b01010, 32'h55);

        rst = 1'b1; arm = 0; frc = 0; fall = 0; fnf = 1; th = 8'h80; len = 0; din = 0;
        repeat (2) @(posedge clk);
        #1;
        check("reset status", 32'({ws, trig, busy, done, ovf}), 32'h0);
        check("reset dout", dout, 32'h0);
        rst = 1'b0;
        step(mk(0, 1, 0, 1, 5, 32'h12345678, 5'b00000, 32'h0), "idle force ignored");

        for (int i = 0; i < 36; i++) step(tbl[i], $sformatf("vec%0d", i));

        step(mk(1, 0, 0, 1, 5, 32'h0, 5'b00100, 32'h55), "rst seq arm");
        step(mk(0, 1, 0, 1, 5, 32'hCAFE0001, 5'b11100, 32'hCAFE0001), "rst seq trigger");
        #2 rst = 1'b1;
        #1;
        check("async reset status", 32'({ws, trig, busy, done, ovf}), 32'h0);
        check("async reset dout", dout, 32'h0);
        @(posedge clk);
        #1 rst = 1'b0;
        step(mk(0, 0, 0, 1, 5, 32'hCAFE0002, 5'b00000, 32'h0), "post reset idle");
        step(mk(0, 1, 0, 1, 5, 32'hCAFE0003, 5'b00000, 32'h0), "post reset force ignored");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/adc_capture_trigger.md
# adc_capture_trigger

Capture controller between the ADC input register and the ADC storage FIFO, clocked in the ADC clock domain. Watches the packed 4-sample ADC word stream for a level crossing (or a forced trigger) after being armed. Emits a fixed-length burst of FIFO write strobes with the aligned data word. Reports trigger, busy, done and overflow status to the command/UART side.

## Interface
Parameters:
- LEN_W, 16: width of RecordLength and the word counter.
- PRE_DEPTH, 8: pre-trigger depth in words; used only with CAPTURE_PRETRIGGER_EN.

Ports:
- Clock  in  1  ADC clock; all logic on its rising edge.
- Reset  in  1  asynchronous, active-high; clears all state and outputs.
- DataIn  in  32  four 8-bit unsigned samples; [31:24] oldest, [7:0] newest.
- Arm  in  1  single-cycle pulse; arms capture.
- ForceTrigger  in  1  trigger immediately when ARMED.
- Threshold  in  8  trigger level.
- FallingSlope  in  1  0 = rising crossing, 1 = falling crossing.
- RecordLength  in  LEN_W  words per record; sampled on Arm.
- FifoNotFull  in  1  from storage FIFO.
- WriteStrobe  out  1  registered FIFO write enable.
- DataOut  out  32  registered word to FIFO.
- Triggered  out  1  high from trigger until next Arm.
- Busy  out  1  high in ARMED or RECORD.
- Done  out  1  high in DONE.
- Overflow  out  1  sticky; a strobe occurred with FifoNotFull low.

## Operation
- States: IDLE, ARMED, RECORD, DONE.
- Reset value: state IDLE, and every output 0.
- IDLE or DONE with Arm=1:
  - go to ARMED;
  - latch RecordLength into len_q;
  - clear Triggered, Overflow and the counter;
  - invalidate the previous-sample register.
- Arm while ARMED or RECORD is ignored.
- Crossing test: each lane compares its predecessor against the current sample. Lane [31:24]'s predecessor is the previous word's [7:0]. That pair is skipped while the previous-sample register is invalid.
  - Rising crossing: prev < Threshold and cur >= Threshold.
  - Falling crossing: prev >= Threshold and cur < Threshold.
- The previous-sample register loads DataIn[7:0] every cycle in ARMED and becomes valid after the first ARMED cycle.
- ARMED with a crossing or ForceTrigger on the current DataIn:
  - if len_q = 0, go to DONE with no strobe;
  - else go to RECORD, set Triggered, write the current word as word 1.
- RECORD: WriteStrobe=1 every cycle, DataOut = DataIn of that edge.
  - counter increments per strobe and returns to DONE when counter = len_q.
  - Exactly len_q strobes are issued.
- FifoNotFull=0 while strobing: the strobe is still issued (the FIFO drops the word), Overflow sets, and counting continues so the record keeps its time alignment.
- Counter arithmetic is LEN_W-bit unsigned; len_q max = 2^LEN_W-1, no wrap.
- Reset mid-record aborts immediately; no further strobes.

## Timing
- One-cycle latency: DataIn sampled at edge n appears on DataOut with WriteStrobe after edge n.
- The triggering word itself is the first word written.
- The last strobe is the len_q-th cycle after the trigger edge; WriteStrobe=0 and Done=1 after the following edge.
- Arm in DONE: Done falls and Busy rises after the same edge.
- Triggered, Busy, Done and Overflow are registered and glitch-free.

## Configuration
- CAPTURE_PRETRIGGER_EN defined:
  - DataOut comes from a PRE_DEPTH-word delay line loaded every cycle.
  - Recorded words start PRE_DEPTH words before the trigger word; strobe count is still len_q.
  - Crossings and ForceTrigger are ignored until PRE_DEPTH words have been loaded since Arm.
- Undefined: no delay line, and behaviour exactly as in Operation.

## Structure
- Shared package holds the state enum (IDLE/ARMED/RECORD/DONE) and the sample/word width constants (8, 32, lanes = 4).
- One sub-module, capture_delay_line: parameterized shift register with a fill counter; instantiated only under CAPTURE_PRETRIGGER_EN.

## Test plan
- Rising trigger: Arm with RecordLength=5, Threshold=0x80, FallingSlope=0; feed words 0x10101010 then 0x10109090.
  - Required: 5 strobes, first DataOut=0x10109090, then Done=1, Triggered=1.
- Falling trigger across words: prev [7:0]=0x90, next [31:24]=0x20, FallingSlope=1.
  - Required: trigger on the second word.
  - Also: right after Arm, a first word starting 0x20 must not trigger.
- ForceTrigger in ARMED with constant 0x00000000 and RecordLength=3.
  - Required: exactly 3 strobes of 0x00000000.
- RecordLength=0 with ForceTrigger.
  - Required: DONE next cycle, zero strobes.
- FifoNotFull low for 2 cycles mid-record (RecordLength=10).
  - Required: 10 strobes total, Overflow=1 until the next Arm.
- Reset asserted during RECORD.
  - Required: WriteStrobe=0 and all outputs 0 immediately, state IDLE.
  - With CAPTURE_PRETRIGGER_EN and PRE_DEPTH=8, a trigger 3 cycles after Arm is ignored.
